noc_local_depacketizer: RTL and testbench
=========================================

// Module: noc_local_depacketizer
// PURPOSE
//  Receive-side network interface at a router LOCAL port. It takes head/body/tail flits from the
//  router's local output and recovers the packet header fields (src id, AXI type, pack order, len).
//  It then streams the payload beats to the local AXI adapter. It is the inverse of the injection
//  packetizer, checks packet framing and destination, and drops malformed or misrouted packets.
// PARAMETERS
//  FLIT_W   64  flit width; bits [FLIT_W-1:FLIT_W-2] = marker, [FLIT_W-3:0] = payload
//  DATA_W   62  beat width, fixed = FLIT_W-2
//  X_W      4   node X id width
//  Y_W      4   node Y id width
//  TYPE_W   2   AXI type field width
//  ORDER_W  4   AXI pack-order field width
//  LEN_W    8   AXI len field width (beats-1)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  my_x         in   X_W      this node X id (static)
//  my_y         in   Y_W      this node Y id (static)
//  flit_valid   in   1        flit from router local port
//  flit_data    in   FLIT_W   flit
//  flit_ready   out  1        flit accepted when valid&ready
//  hdr_valid    out  1        header fields valid
//  hdr_ready    in   1        header consumed
//  hdr_src_x    out  X_W      source X
//  hdr_src_y    out  Y_W      source Y
//  hdr_type     out  TYPE_W   AXI type
//  hdr_order    out  ORDER_W  pack order
//  hdr_len      out  LEN_W    AXI len (body beats = len+1; 0 beats for single-flit packets)
//  beat_valid   out  1        payload beat valid
//  beat_ready   in   1        payload beat consumed
//  beat_data    out  DATA_W   payload = flit_data[DATA_W-1:0]
//  beat_last    out  1        final beat of packet
//  err_misroute out  1        1-cycle pulse: dst != {my_x,my_y}
//  err_frame    out  1        1-cycle pulse: framing error
// BEHAVIOUR
//  Markers: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail, no body).
//  Header payload fields, LSB up: dst_x[X_W], dst_y[Y_W], src_x, src_y, type, order, len. Upper bits ignored.
//  Reset: state=S_HEAD. hdr_valid, beat_valid, beat_last, err_* = 0. All data regs = 0.
//   A reset mid-packet discards the partial packet.
//  FSM:
//   S_HEAD : flit_ready=1.
//     - Head or single marker with dst == my id: register fields, hdr_valid=1 next cycle (latency 1),
//       go S_HDR.
//     - dst != my id: err_misroute pulse. Head -> S_DRAIN; single -> stay in S_HEAD.
//     - Body or tail marker: err_frame pulse, flit dropped, stay in S_HEAD.
//   S_HDR  : flit_ready=0. Hold hdr_* stable until hdr_valid&hdr_ready.
//     - Single packet -> S_HEAD.
//     - Otherwise load cnt=hdr_len, go S_BODY.
//   S_BODY : flit_ready = !beat_valid | beat_ready (1 flit/cycle sustained).
//     - Accepted body/tail flit -> beat_valid next cycle (latency 1).
//     - beat_last=1 when cnt==0. cnt decrements per accepted flit.
//     - Tail with cnt==0: go S_HEAD after the beat is accepted downstream; next head is accepted
//       the same cycle the last beat leaves.
//     - Tail with cnt!=0 (early tail): beat issued with beat_last=1, err_frame pulse, -> S_HEAD.
//     - Body with cnt==0 (missing tail): beat issued with beat_last=1, err_frame, -> S_DRAIN.
//     - Head or single marker in S_BODY: err_frame, flit dropped, state kept.
//   S_DRAIN: flit_ready=1. Discard flits until a tail, then -> S_HEAD. No beats, no header.
//  beat_* and hdr_* hold stable while valid & !ready. cnt is LEN_W bits and never wraps: 0 is terminal.
//  hdr_valid and beat_valid are never high together.
//  err_* are single-cycle pulses. Two errors never occur in the same cycle.
// TESTING
//  1. my=(1,2). Head dst=(1,2) src=(3,0) type=1 order=5 len=2, then body A,B, tail C, all ready=1
//     -> hdr 1 cycle after head; beats A,B,C back-to-back; beat_last only on C; no err.
//  2. Single flit dst=(1,2) len=7 -> hdr_valid with len=7, no beats; next head accepted right after hdr_ready.
//  3. Head dst=(0,0) + 3 body + tail -> err_misroute=1 for exactly 1 cycle; all 5 flits consumed; no hdr/beat output.
//  4. len=3 but tail after 1 body -> 2 beats, 2nd has beat_last=1; err_frame pulse; next packet decodes correctly.
//  5. beat_ready toggles 1010... during a len=15 packet -> 16 beats in order, none lost or duplicated;
//     flit_ready low whenever a beat is held.
//  6. rst_n low mid-body of a len=4 packet, then a fresh packet -> all outputs 0 during reset;
//     new packet decoded cleanly; stale flits are not emitted.

Source files
------------

// File: rtl/noc_local_depacketizer_if.sv
// Flit input, header output and payload beat output of the local-port depacketizer.
// The slave modport is the depacketizer itself; master is the router/adapter side.
interface noc_local_depacketizer_if #(
  parameter int FLIT_W  = 64,
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int TYPE_W  = 2,
  parameter int ORDER_W = 4,
  parameter int LEN_W   = 8
);
  localparam int DATA_W = FLIT_W - 2;

  // Every channel transfers on a cycle where valid and ready are both high at the
  // rising clock edge; a producer keeps valid and its payload stable until then.
  logic                flit_valid;
  logic [FLIT_W-1:0]   flit_data;
  logic                flit_ready;

  logic                hdr_valid;
  logic                hdr_ready;
  logic [X_W-1:0]      hdr_src_x;
  logic [Y_W-1:0]      hdr_src_y;
  logic [TYPE_W-1:0]   hdr_type;
  logic [ORDER_W-1:0]  hdr_order;
  logic [LEN_W-1:0]    hdr_len;

  logic                beat_valid;
  logic                beat_ready;
  logic [DATA_W-1:0]   beat_data;
  logic                beat_last;

  logic                err_misroute;
  logic                err_frame;

  modport slave (
    input  flit_valid, flit_data, hdr_ready, beat_ready,
    output flit_ready, hdr_valid, hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len,
           beat_valid, beat_data, beat_last, err_misroute, err_frame
  );

  modport master (
    output flit_valid, flit_data, hdr_ready, beat_ready,
    input  flit_ready, hdr_valid, hdr_src_x, hdr_src_y, hdr_type, hdr_order, hdr_len,
           beat_valid, beat_data, beat_last, err_misroute, err_frame
  );
endinterface

// File: rtl/noc_local_depacketizer.sv
// Local-port receive NI: decodes head flits into header fields, streams body/tail payload
// as AXI beats, and drops misrouted or badly framed packets with one-cycle error pulses.
module noc_local_depacketizer #(
  parameter int FLIT_W  = 64,
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int TYPE_W  = 2,
  parameter int ORDER_W = 4,
  parameter int LEN_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [X_W-1:0]        my_x,
  input  logic [Y_W-1:0]        my_y,
  noc_local_depacketizer_if.slave bus,
  output logic [1:0]            dbg_state_o
);
  localparam int DATA_W = FLIT_W - 2;
  localparam int DX_LSB = 0;
  localparam int DY_LSB = X_W;
  localparam int SX_LSB = X_W + Y_W;
  localparam int SY_LSB = 2 * X_W + Y_W;
  localparam int TY_LSB = 2 * X_W + 2 * Y_W;
  localparam int OR_LSB = TY_LSB + TYPE_W;
  localparam int LN_LSB = OR_LSB + ORDER_W;

  localparam logic [1:0] M_BODY = 2'b00;
  localparam logic [1:0] M_TAIL = 2'b01;

  typedef enum logic [1:0] {
    S_HEAD  = 2'd0,
    S_HDR   = 2'd1,
    S_BODY  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic                single_q, single_d;
  logic [X_W-1:0]      src_x_q, src_x_d;
  logic [Y_W-1:0]      src_y_q, src_y_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [ORDER_W-1:0]  order_q, order_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                beat_valid_q, beat_valid_d;
  logic [DATA_W-1:0]   beat_data_q, beat_data_d;
  logic                beat_last_q, beat_last_d;
  logic                err_misroute_q, err_misroute_d;
  logic                err_frame_q, err_frame_d;

  logic [1:0]          marker;
  logic [DATA_W-1:0]   payload;
  logic                is_head;
  logic                is_tail;
  logic                dst_hit;
  logic                beat_free;
  logic                flit_ready;

  assign marker    = bus.flit_data[FLIT_W-1 -: 2];
  assign payload   = bus.flit_data[DATA_W-1:0];
  assign is_head   = marker[1];
  assign is_tail   = (marker == M_TAIL);
  assign dst_hit   = (payload[DX_LSB +: X_W] == my_x) && (payload[DY_LSB +: Y_W] == my_y);
  assign beat_free = !beat_valid_q || bus.beat_ready;

  always_comb begin
    state_d        = state_q;
    hdr_valid_d    = hdr_valid_q;
    single_d       = single_q;
    src_x_d        = src_x_q;
    src_y_d        = src_y_q;
    type_d         = type_q;
    order_d        = order_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    beat_valid_d   = beat_valid_q && !bus.beat_ready;
    beat_data_d    = beat_data_q;
    beat_last_d    = beat_last_q;
    err_misroute_d = 1'b0;
    err_frame_d    = 1'b0;
    flit_ready     = 1'b0;

    unique case (state_q)
      S_HEAD: begin
        // A final beat may still be waiting downstream; the next head only enters as it
        // leaves, so a header is never presented alongside a beat.
        flit_ready = beat_free;
        if (bus.flit_valid && beat_free) begin
          if (is_head && dst_hit) begin
            src_x_d     = payload[SX_LSB +: X_W];
            src_y_d     = payload[SY_LSB +: Y_W];
            type_d      = payload[TY_LSB +: TYPE_W];
            order_d     = payload[OR_LSB +: ORDER_W];
            len_d       = payload[LN_LSB +: LEN_W];
            single_d    = marker[0];
            hdr_valid_d = 1'b1;
            state_d     = S_HDR;
          end else if (is_head) begin
            err_misroute_d = 1'b1;
            if (!marker[0]) state_d = S_DRAIN;
          end else begin
            err_frame_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (bus.hdr_ready) begin
          hdr_valid_d = 1'b0;
          cnt_d       = len_q;
          state_d     = single_q ? S_HEAD : S_BODY;
        end
      end
      S_BODY: begin
        flit_ready = beat_free;
        if (bus.flit_valid && beat_free) begin
          if (is_head) begin
            err_frame_d = 1'b1;
          end else begin
            beat_valid_d = 1'b1;
            beat_data_d  = payload;
            beat_last_d  = is_tail || (cnt_q == '0);
            if (is_tail) begin
              err_frame_d = (cnt_q != '0);
              state_d     = S_HEAD;
            end else if (cnt_q == '0) begin
              err_frame_d = 1'b1;
              state_d     = S_DRAIN;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        flit_ready = 1'b1;
        if (bus.flit_valid && is_tail) state_d = S_HEAD;
      end
      default: state_d = S_HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_HEAD;
      hdr_valid_q    <= 1'b0;
      single_q       <= 1'b0;
      src_x_q        <= '0;
      src_y_q        <= '0;
      type_q         <= '0;
      order_q        <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      beat_valid_q   <= 1'b0;
      beat_data_q    <= '0;
      beat_last_q    <= 1'b0;
      err_misroute_q <= 1'b0;
      err_frame_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_valid_q    <= hdr_valid_d;
      single_q       <= single_d;
      src_x_q        <= src_x_d;
      src_y_q        <= src_y_d;
      type_q         <= type_d;
      order_q        <= order_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      beat_valid_q   <= beat_valid_d;
      beat_data_q    <= beat_data_d;
      beat_last_q    <= beat_last_d;
      err_misroute_q <= err_misroute_d;
      err_frame_q    <= err_frame_d;
    end
  end

  assign bus.flit_ready   = flit_ready;
  assign bus.hdr_valid    = hdr_valid_q;
  assign bus.hdr_src_x    = src_x_q;
  assign bus.hdr_src_y    = src_y_q;
  assign bus.hdr_type     = type_q;
  assign bus.hdr_order    = order_q;
  assign bus.hdr_len      = len_q;
  assign bus.beat_valid   = beat_valid_q;
  assign bus.beat_data    = beat_data_q;
  assign bus.beat_last    = beat_last_q;
  assign bus.err_misroute = err_misroute_q;
  assign bus.err_frame    = err_frame_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_noc_local_depacketizer.sv
// Directed bench for noc_local_depacketizer: scoreboarded headers and beats, error pulse
// counting, reset behaviour and back-pressure handling.
module tb_noc_local_depacketizer;
  localparam int FLIT_W  = 64;
  localparam int X_W     = 4;
  localparam int Y_W     = 4;
  localparam int TYPE_W  = 2;
  localparam int ORDER_W = 4;
  localparam int LEN_W   = 8;

  localparam logic [1:0] M_BODY   = 2'b00;
  localparam logic [1:0] M_TAIL   = 2'b01;
  localparam logic [1:0] M_HEAD   = 2'b10;
  localparam logic [1:0] M_SINGLE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  my_x;
  logic [3:0]  my_y;
  logic [1:0]  dbg_state;
  logic        hdr_rdy;
  logic        beat_rdy;
  logic        toggle_en;
  logic        tog = 1'b0;
  logic        chk_hold;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_misroute = 0;
  int          n_frame = 0;

  logic [21:0] exp_hdr_q[$];
  logic [62:0] exp_beat_q[$];
  int          beat_cyc_q[$];

  logic        prev_hold = 1'b0;
  logic [62:0] prev_beat = '0;

  noc_local_depacketizer_if #(
    .FLIT_W(FLIT_W), .X_W(X_W), .Y_W(Y_W), .TYPE_W(TYPE_W), .ORDER_W(ORDER_W), .LEN_W(LEN_W)
  ) bus ();

  noc_local_depacketizer #(
    .FLIT_W(FLIT_W), .X_W(X_W), .Y_W(Y_W), .TYPE_W(TYPE_W), .ORDER_W(ORDER_W), .LEN_W(LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .my_x       (my_x),
    .my_y       (my_y),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  assign bus.hdr_ready  = hdr_rdy;
  assign bus.beat_ready = toggle_en ? tog : beat_rdy;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    tog = ~tog;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [61:0] hdr_pl(input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [3:0] sx, input logic [3:0] sy,
                                         input logic [1:0] t, input logic [3:0] o,
                                         input logic [7:0] l);
    return {32'd0, l, o, t, sy, sx, dy, dx};
  endfunction

  function automatic logic [61:0] rnd62();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[61:0];
  endfunction

  task automatic push_hdr(input logic [3:0] sx, input logic [3:0] sy, input logic [1:0] t,
                          input logic [3:0] o, input logic [7:0] l);
    exp_hdr_q.push_back({sx, sy, t, o, l});
  endtask

  task automatic push_beat(input logic last, input logic [61:0] d);
    exp_beat_q.push_back({last, d});
  endtask

  // Driver: present one flit and hold it until the DUT accepts it
  task automatic send_flit(input logic [1:0] m, input logic [61:0] p, output int acc);
    int w;
    w = 0;
    bus.flit_valid = 1'b1;
    bus.flit_data  = {m, p};
    @(negedge clk);
    while (!bus.flit_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("flit_accept_wait", 64'(w < 100), 64'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.flit_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [61:0] p);
    int acc;
    send_flit(m, p, acc);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((exp_hdr_q.size() != 0 || exp_beat_q.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_hdr_left"}, 64'(exp_hdr_q.size()), 64'd0);
    check({tag, "_beat_left"}, 64'(exp_beat_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {60'd0, bus.hdr_valid, bus.beat_valid, bus.beat_last, 1'b0}, 64'd0);
    check({tag, "_errs"}, {62'd0, bus.err_misroute, bus.err_frame}, 64'd0);
    check({tag, "_hdr"}, {42'd0, bus.hdr_src_x, bus.hdr_src_y, bus.hdr_type, bus.hdr_order,
                          bus.hdr_len}, 64'd0);
    check({tag, "_beat_data"}, {2'd0, bus.beat_data}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [21:0] eh;
    logic [62:0] eb;
    if (rst_n) begin
      if (bus.hdr_valid && bus.hdr_ready) begin
        check("hdr_expected", 64'(exp_hdr_q.size() != 0), 64'd1);
        if (exp_hdr_q.size() != 0) begin
          eh = exp_hdr_q.pop_front();
          check("hdr_fields", {42'd0, bus.hdr_src_x, bus.hdr_src_y, bus.hdr_type,
                               bus.hdr_order, bus.hdr_len}, {42'd0, eh});
        end
      end
      if (bus.beat_valid && bus.beat_ready) begin
        beat_cyc_q.push_back(cyc);
        check("beat_expected", 64'(exp_beat_q.size() != 0), 64'd1);
        if (exp_beat_q.size() != 0) begin
          eb = exp_beat_q.pop_front();
          check("beat_last_data", {1'b0, bus.beat_last, bus.beat_data}, {1'b0, eb});
        end
      end
      if (prev_hold)
        check("beat_stable", {1'b0, bus.beat_valid, bus.beat_data}, {2'b01, prev_beat[61:0]});
      prev_hold = bus.beat_valid && !bus.beat_ready;
      prev_beat = {bus.beat_last, bus.beat_data};
      check("hdr_beat_excl", 64'(bus.hdr_valid & bus.beat_valid), 64'd0);
      check("err_excl", 64'(bus.err_misroute & bus.err_frame), 64'd0);
      if (chk_hold && bus.beat_valid && !bus.beat_ready)
        check("flit_ready_when_held", 64'(bus.flit_ready), 64'd0);
      if (bus.err_misroute) n_misroute++;
      if (bus.err_frame) n_frame++;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    int m0;
    int f0;
    logic [61:0] d[0:15];

    my_x = 4'd1;
    my_y = 4'd2;
    bus.flit_valid = 1'b0;
    bus.flit_data  = '0;
    hdr_rdy   = 1'b1;
    beat_rdy  = 1'b1;
    toggle_en = 1'b0;
    chk_hold  = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = rnd62();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: head + 2 body + tail, all ready
    m0 = n_misroute;
    f0 = n_frame;
    push_hdr(4'd3, 4'd0, 2'd1, 4'd5, 8'd2);
    push_beat(1'b0, d[0]);
    push_beat(1'b0, d[1]);
    push_beat(1'b1, d[2]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd3, 4'd0, 2'd1, 4'd5, 8'd2));
    check("t1_hdr_latency", 64'(bus.hdr_valid), 64'd1);
    beat_cyc_q.delete();
    send(M_BODY, d[0]);
    send(M_BODY, d[1]);
    send(M_TAIL, d[2]);
    drain("t1");
    check("t1_beat_count", 64'(beat_cyc_q.size()), 64'd3);
    if (beat_cyc_q.size() == 3)
      check("t1_back_to_back", 64'(beat_cyc_q[2] - beat_cyc_q[0]), 64'd2);
    check("t1_no_err", 64'((n_misroute - m0) + (n_frame - f0)), 64'd0);

    // 2: single flit, then the next head right after hdr_ready
    push_hdr(4'd2, 4'd1, 2'd2, 4'd3, 8'd7);
    send_flit(M_SINGLE, hdr_pl(4'd1, 4'd2, 4'd2, 4'd1, 2'd2, 4'd3, 8'd7), a);
    push_hdr(4'd4, 4'd4, 2'd0, 4'd0, 8'd0);
    push_beat(1'b1, d[3]);
    send_flit(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd4, 4'd4, 2'd0, 4'd0, 8'd0), b);
    check("t2_next_head_cycle", 64'(b - a), 64'd2);
    send(M_TAIL, d[3]);
    drain("t2");

    // 3: misrouted packet is drained silently
    m0 = n_misroute;
    f0 = n_frame;
    send(M_HEAD, hdr_pl(4'd0, 4'd0, 4'd3, 4'd3, 2'd1, 4'd1, 8'd3));
    send(M_BODY, d[4]);
    send(M_BODY, d[5]);
    send(M_BODY, d[6]);
    send(M_TAIL, d[7]);
    drain("t3");
    check("t3_misroute_cycles", 64'(n_misroute - m0), 64'd1);
    check("t3_no_frame", 64'(n_frame - f0), 64'd0);
    check("t3_state_head", 64'(dbg_state), 64'd0);

    // 4: early tail, then a clean packet
    f0 = n_frame;
    push_hdr(4'd5, 4'd6, 2'd3, 4'd9, 8'd3);
    push_beat(1'b0, d[8]);
    push_beat(1'b1, d[9]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd5, 4'd6, 2'd3, 4'd9, 8'd3));
    send(M_BODY, d[8]);
    send(M_TAIL, d[9]);
    drain("t4a");
    check("t4_frame_pulse", 64'(n_frame - f0), 64'd1);
    push_hdr(4'd7, 4'd8, 2'd1, 4'd2, 8'd1);
    push_beat(1'b0, d[10]);
    push_beat(1'b1, d[11]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd7, 4'd8, 2'd1, 4'd2, 8'd1));
    send(M_BODY, d[10]);
    send(M_TAIL, d[11]);
    drain("t4b");
    check("t4_frame_after", 64'(n_frame - f0), 64'd1);

    // 5: len=15 with beat_ready toggling
    push_hdr(4'd1, 4'd1, 2'd0, 4'd0, 8'd15);
    toggle_en = 1'b1;
    chk_hold  = 1'b1;
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd1, 4'd1, 2'd0, 4'd0, 8'd15));
    for (int i = 0; i < 16; i++) begin
      push_beat(i == 15, d[i]);
      send((i == 15) ? M_TAIL : M_BODY, d[i]);
    end
    drain("t5");
    toggle_en = 1'b0;
    chk_hold  = 1'b0;

    // 6: reset mid-body, then a fresh packet
    push_hdr(4'd2, 4'd2, 2'd1, 4'd1, 8'd4);
    push_beat(1'b0, d[12]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd2, 4'd2, 2'd1, 4'd1, 8'd4));
    send(M_BODY, d[12]);
    send(M_BODY, d[13]);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_in_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_hdr(4'd3, 4'd3, 2'd2, 4'd2, 8'd1);
    push_beat(1'b0, d[14]);
    push_beat(1'b1, d[15]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd3, 4'd3, 2'd2, 4'd2, 8'd1));
    send(M_BODY, d[14]);
    send(M_TAIL, d[15]);
    drain("t6");

    // 7: stray body, head inside body, missing tail
    f0 = n_frame;
    send(M_BODY, d[0]);
    drain("t7a");
    check("t7_stray_body", 64'(n_frame - f0), 64'd1);
    push_hdr(4'd6, 4'd5, 2'd3, 4'd7, 8'd1);
    push_beat(1'b0, d[1]);
    push_beat(1'b1, d[2]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd6, 4'd5, 2'd3, 4'd7, 8'd1));
    send(M_BODY, d[1]);
    send(M_HEAD, d[3]);
    send(M_TAIL, d[2]);
    drain("t7b");
    check("t7_head_in_body", 64'(n_frame - f0), 64'd2);
    push_hdr(4'd9, 4'd9, 2'd0, 4'd1, 8'd0);
    push_beat(1'b1, d[4]);
    send(M_HEAD, hdr_pl(4'd1, 4'd2, 4'd9, 4'd9, 2'd0, 4'd1, 8'd0));
    send(M_BODY, d[4]);
    send(M_BODY, d[5]);
    send(M_TAIL, d[6]);
    drain("t7c");
    check("t7_missing_tail", 64'(n_frame - f0), 64'd3);
    check("t7_state_head", 64'(dbg_state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
